// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Tracks in-flight destinations in a three-slot scoreboard (EX, MEM, WB).
// Resolves RAW hazards by forwarding, stalls one cycle on load-use, and
// flushes IF/ID on a taken branch. Saturating counters track stall/flush.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   id_valid                  : ID holds a valid instruction
//   id_rs, id_rt              : ID source register addresses
//   id_rs_used, id_rt_used    : the source is actually read
//   id_we, id_waddr           : ID writes id_waddr
//   id_is_load                : ID instruction is a load
//   ex_br_taken               : branch/jump resolved taken in EX
//   mem_stall_req             : data memory not ready, freeze pipeline
//   stall, flush              : pipeline controls (same-cycle)
//   fwd_a, fwd_b              : operand source (00 RF, 01 EX, 10 MEM, 11 WB)
//   stall_cnt, flush_cnt      : saturating performance counters
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_we,
  input  logic [4:0]       id_waddr,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_stall_req,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] waddr;
    logic       ld;
  } slot_t;

  localparam slot_t            BUBBLE  = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t            ex_q, mem_q, wb_q;
  slot_t            ex_d, mem_d, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;

  // A slot produces register r; r0 is never a real destination.
  function automatic logic writes(input slot_t s, input logic [4:0] r);
    return s.v && s.we && (s.waddr == r) && (r != 5'd0);
  endfunction

  // Youngest producer wins; a load still in EX cannot forward (lu stalls it).
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] r,
                                         input slot_t ex, input slot_t mem,
                                         input slot_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      if (writes(ex, r))       sel = ex.ld ? 2'b00 : 2'b01;
      else if (writes(mem, r)) sel = 2'b10;
      else if (writes(wb, r))  sel = 2'b11;
    end
    return sel;
  endfunction

  // Hazard detection and pipeline controls; all forced quiet during reset.
  always_comb begin
    lu    = id_valid && ex_q.ld &&
            ((id_rs_used && writes(ex_q, id_rs)) ||
             (id_rt_used && writes(ex_q, id_rt)));
    stall = 1'b0;
    flush = 1'b0;
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (mem_stall_req)    stall = 1'b1;
      else if (ex_br_taken) flush = 1'b1;
      else if (lu)          stall = 1'b1;
      fwd_a = fwd_sel(id_rs_used, id_rs, ex_q, mem_q, wb_q);
      fwd_b = fwd_sel(id_rt_used, id_rt, ex_q, mem_q, wb_q);
    end
  end

  // Scoreboard advance: freeze holds, branch/load-use inject a bubble into EX.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_stall_req) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = BUBBLE;
      if (!ex_br_taken && !lu && id_valid) begin
        ex_d.v     = 1'b1;
        ex_d.we    = id_we;
        ex_d.waddr = id_waddr;
        ex_d.ld    = id_is_load;
      end
    end
  end

  // Saturating counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller that sequences the register file and the ID/EX/MEM/WB pipeline.
- Tracks in-flight destination registers in a three-slot scoreboard (EX, MEM, WB).
- Resolves read-after-write hazards by operand forwarding where possible. Stalls one cycle on load-use.
- Generates the `stall`/`flush` controls consumed by the register file and the pipeline registers. Also keeps saturating performance counters.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall and flush performance counters.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `id_valid` input 1: valid instruction in ID this cycle.
- `id_rs`, `id_rt` input 5 each: source register addresses of the ID instruction.
- `id_rs_used`, `id_rt_used` input 1 each: the source is actually read.
- `id_we` input 1: the ID instruction writes a register.
- `id_waddr` input 5: destination register of the ID instruction.
- `id_is_load` input 1: the ID instruction is a load; its result is available only after MEM.
- `ex_br_taken` input 1: branch/jump resolved taken in EX this cycle.
- `mem_stall_req` input 1: data memory not ready; freeze the whole pipeline.
- `stall` output 1: hold PC, IF/ID and regfile read registers.
- `flush` output 1: squash the IF/ID contents.
- `fwd_a`, `fwd_b` output 2 each: operand source select for rs/rt.
  - 00 = regfile, 01 = EX result, 10 = MEM result, 11 = WB result.
- `stall_cnt` output CNT_W: cycles in which `stall` was high (saturating).
- `flush_cnt` output CNT_W: cycles in which `flush` was high (saturating).

## Operation
- Scoreboard: three slots, EX, MEM and WB. Each slot holds {v, we, waddr[4:0], ld}.
  - A slot "writes r" when v && we && waddr==r && r!=0.
  - Register 0 never matches anything.
- Hazard conditions, evaluated combinationally from the current slots and ID inputs:
  - `lu` (load-use) = id_valid && EX.ld && EX writes a used source (rs with id_rs_used, or rt with id_rt_used).
  - `freeze` = mem_stall_req.
- Control priority: rst > freeze > ex_br_taken > lu > normal.
  - freeze: stall=1, flush=0. All slots hold their value; counters only count stall.
  - ex_br_taken (no freeze): flush=1, stall=0.
    - EX←bubble, because the ID instruction is squashed.
    - MEM←EX and WB←MEM. The branch itself advances.
  - lu (no freeze, no branch): stall=1, flush=0. EX←bubble, MEM←EX, WB←MEM.
  - normal: stall=0, flush=0.
    - EX←{id_valid, id_we, id_waddr, id_is_load}; an invalid ID instruction gives a bubble with v=0.
    - MEM←EX and WB←MEM.
- A bubble is v=0 and all other fields 0.
- Forwarding, per source, with priority EX > MEM > WB:
  - `fwd_a` = 01 if EX writes rs and !EX.ld; else 10 if MEM writes rs; else 11 if WB writes rs; else 00.
  - `fwd_b` is computed identically on rt.
  - A source whose `used` flag is 0 gets 00.
  - A matching EX load gives 00. That case stalls via `lu`, and after the bubble it matches MEM and gets 10.
- Counters: while not at the maximum, increment by 1 in each cycle the respective output is high; hold at 2^CNT_W−1.

## Timing
- Reset, on a rising edge with rst=1:
  - All slots become bubbles; stall_cnt=0 and flush_cnt=0.
  - While rst is high, stall=0, flush=0 and fwd_a=fwd_b=00, independent of the other inputs.
- `stall`, `flush`, `fwd_*` are combinational from the current slots and inputs (same-cycle).
- Slots and counters update at the clock edge.
- Load-use penalty is exactly 1 cycle.
  - After the stall edge, EX holds a bubble and MEM holds the load, so `lu` is 0 and the instruction issues next cycle with fwd=10.
- Branch penalty is 1 flushed slot. ex_br_taken and lu in the same cycle: flush wins, stall=0.
- ex_br_taken during freeze is ignored. The EX stage holds the branch, so it reasserts after the freeze.
- Back-to-back load-use on a new instruction is allowed; each costs 1 cycle.
- A reset asserted mid-stall or mid-freeze clears everything on that edge. No partial state survives.

## Test plan
- Reset: assert rst 2 cycles while mem_stall_req=1 and ex_br_taken=1 → stall=0, flush=0, fwd=00, counters 0; after deassert, all slots are bubbles.
- EX forward: issue `add r3` (we, waddr=3), then next cycle ID uses rs=3 → fwd_a=01; in the following cycles, with the reader replaced by a non-matching one, the match moves to 10, then 11, then 00.
- Load-use: issue load to r5; next cycle ID uses rt=5 → stall=1 for exactly 1 cycle and stall_cnt=1; the next cycle gives fwd_b=10 and stall=0.
- r0 / unused source: a writer to r0 followed by a reader of r0, and a writer to r7 followed by id_rs=7 with id_rs_used=0 → fwd=00, no stall.
- Branch vs load-use: EX holds a load to r2, ID reads r2, and ex_br_taken=1 in the same cycle → flush=1, stall=0, EX←bubble, flush_cnt increments.
- Freeze and saturation: mem_stall_req=1 for 3 cycles with a load in EX → slots unchanged and stall_cnt+3; with CNT_W=2, hold stall for 5 cycles → stall_cnt=3.
